// File: rtl/crank_gen_pkg.sv
// Shared constants and types for the crank/cam pattern generator.
// The cam output logic is built only when CRANK_GEN_CAM_EN is defined.
package crank_gen_pkg;

  localparam int unsigned TEETH_DEF   = 60;
  localparam int unsigned MISSING_DEF = 2;

  // Ticks per physical tooth and the last tick index of the gap tooth (191)
  localparam int unsigned TOOTH_TICKS  = 64;
  localparam int unsigned GAP_TICK_TOP = TOOTH_TICKS * (MISSING_DEF + 1) - 1;

  localparam int unsigned CAM_TOOTH_RISE  = 4;
  localparam int unsigned CAM_TOOTH_PHASE = 30;
  localparam int unsigned CAM_TOOTH_FALL  = 54;

  localparam int unsigned PERIOD_W = 8;
  localparam int unsigned TCKC_W   = 8;
  localparam int unsigned TOOTH_W  = 6;

  typedef logic [PERIOD_W-1:0] period_t;
  typedef logic [TCKC_W-1:0]   tckc_t;
  typedef logic [TOOTH_W-1:0]  tooth_t;

  // Last tick index of the tooth that absorbs the missing teeth
  function automatic tckc_t gap_top(input int unsigned missing);
    return tckc_t'(TOOTH_TICKS * (missing + 1) - 1);
  endfunction

endpackage

// File: rtl/crank_cam_gen_tick_prescaler.sv
// Tick prescaler: free-running cycle counter with a live top value and a
// shadow top that is only transferred into the live top at revolution wrap.
module tick_prescaler
  import crank_gen_pkg::*;
#(
  parameter period_t RST_PERIOD = 8'd63
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    ena_i,
  input  logic    period_wr_i,
  input  period_t period_data_i,
  input  logic    rev_wrap_i,
  output logic    tick_o,
  output logic    period_pend_o
);

  period_t scnt_q, scnt_d;
  period_t top_q, top_d;
  period_t shadow_q, shadow_d;
  logic    pend_q, pend_d;

  assign tick_o        = ena_i && (scnt_q == top_q);
  assign period_pend_o = pend_q;

  // period_wr_i is a one-cycle strobe with no back-pressure: every strobe
  // seen while enabled overwrites the shadow. A strobe on the wrap cycle
  // loses the race, so the old shadow goes live and pending stays set.
  always_comb begin
    scnt_d   = scnt_q;
    top_d    = top_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (ena_i) begin
      scnt_d = tick_o ? '0 : scnt_q + period_t'(1);
      if (rev_wrap_i) begin
        top_d  = shadow_q;
        pend_d = 1'b0;
      end
      if (period_wr_i) begin
        shadow_d = period_data_i;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scnt_q   <= '0;
      top_q    <= RST_PERIOD;
      shadow_q <= RST_PERIOD;
      pend_q   <= 1'b0;
    end else begin
      scnt_q   <= scnt_d;
      top_q    <= top_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: rtl/crank_cam_gen.sv
// Crank (60-2 style) and cam signal generator driven by a programmable tick.
// Cam logic is present only when CRANK_GEN_CAM_EN is defined; otherwise cam is 0.
module crank_cam_gen
  import crank_gen_pkg::*;
#(
  parameter int unsigned TEETH       = TEETH_DEF,
  parameter int unsigned MISSING     = MISSING_DEF,
  parameter int unsigned START_TOOTH = 53,
  parameter period_t     RST_PERIOD  = 8'd63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          period_wr,
  input  logic [7:0]    period_data,
  output logic          vr,
  output logic          cam,
  output logic [5:0]    tooth,
  output logic          rev_stb,
  output logic          period_pend
);

  localparam tooth_t LAST_TOOTH = tooth_t'(TEETH - MISSING - 1);
  localparam tooth_t START_IDX  = tooth_t'(START_TOOTH);
  localparam tckc_t  NORM_TOP   = tckc_t'(TOOTH_TICKS - 1);
  localparam tckc_t  GAP_TOP    = gap_top(MISSING);

  tckc_t  tckc_q, tckc_d;
  tooth_t tooth_q, tooth_d;
  logic   vr_q, vr_d;

  logic   tick;
  logic   tooth_last;
  logic   tckc_wrap;
  logic   rev_wrap;
  tckc_t  tckc_top;

  tick_prescaler #(
    .RST_PERIOD(RST_PERIOD)
  ) u_prescaler (
    .clk_i         (clk),
    .rst_i         (rst),
    .ena_i         (ena),
    .period_wr_i   (period_wr),
    .period_data_i (period_data),
    .rev_wrap_i    (rev_wrap),
    .tick_o        (tick),
    .period_pend_o (period_pend)
  );

  // tick already carries ena, so everything below freezes with it
  assign tooth_last = (tooth_q == LAST_TOOTH);
  assign tckc_top   = tooth_last ? GAP_TOP : NORM_TOP;
  assign tckc_wrap  = tick && (tckc_q == tckc_top);
  assign rev_wrap   = tckc_wrap && tooth_last;

  always_comb begin
    tckc_d  = tckc_q;
    tooth_d = tooth_q;
    vr_d    = vr_q;
    if (tick) begin
      tckc_d = tckc_wrap ? '0 : tckc_q + tckc_t'(1);
      if (tckc_q == (tckc_top >> 1)) begin
        vr_d = 1'b1;
      end
      if (tckc_wrap) begin
        vr_d    = 1'b0;
        tooth_d = tooth_last ? '0 : tooth_q + tooth_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tckc_q  <= '0;
      tooth_q <= START_IDX;
      vr_q    <= 1'b0;
    end else begin
      tckc_q  <= tckc_d;
      tooth_q <= tooth_d;
      vr_q    <= vr_d;
    end
  end

  assign vr      = vr_q;
  assign tooth   = tooth_q;
  assign rev_stb = rev_wrap;

`ifdef CRANK_GEN_CAM_EN
  logic cam_q, cam_d;
  logic phase_q, phase_d;

  // Decisions use the tooth being left and the phase before any toggle
  always_comb begin
    cam_d   = cam_q;
    phase_d = phase_q;
    if (tckc_wrap) begin
      if (tooth_q == tooth_t'(CAM_TOOTH_PHASE)) begin
        phase_d = ~phase_q;
      end
      if (phase_q && (tooth_q == tooth_t'(CAM_TOOTH_FALL))) begin
        cam_d = 1'b0;
      end
      if (phase_q && (tooth_q == tooth_t'(CAM_TOOTH_RISE))) begin
        cam_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cam_q   <= 1'b1;
      phase_q <= 1'b0;
    end else begin
      cam_q   <= cam_d;
      phase_q <= phase_d;
    end
  end

  assign cam = cam_q;
`else
  assign cam = 1'b0;
`endif

endmodule

// File: doc/crank_cam_gen.md
CRANK_CAM_GEN -- requirements
Module: crank_cam_gen

Interface
REQ-001 SHALL have parameter TEETH, default 60, physical tooth positions per revolution.
REQ-002 SHALL have parameter MISSING, default 2, missing teeth forming the gap.
REQ-003 SHALL have parameter START_TOOTH, default 53, tooth index after reset.
REQ-004 SHALL have parameter RST_PERIOD, default 8'd63, prescaler top after reset.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port ena, input, 1, advance enable; low freezes all state and outputs.
REQ-008 SHALL have port period_wr, input, 1, one-cycle write strobe for period_data.
REQ-009 SHALL have port period_data, input, 8, new prescaler top.
REQ-010 SHALL have port vr, output, 1, crank tooth signal.
REQ-011 SHALL have port cam, output, 1, cam signal.
REQ-012 SHALL have port tooth, output, 6, current tooth index, 0..TEETH-MISSING-1.
REQ-013 SHALL have port rev_stb, output, 1, one-cycle pulse on revolution wrap.
REQ-014 SHALL have port period_pend, output, 1, shadow period not yet applied.

Function
REQ-015 SHALL count scnt 0..scnt_top; tick asserts on the cycle scnt==scnt_top, then scnt returns to 0 (tick period scnt_top+1 cycles).
REQ-016 SHALL count tckc 0..tckc_top on ticks; tckc_top is 63 for normal teeth and 64*(MISSING+1)-1 (191) for tooth TEETH-MISSING-1.
REQ-017 SHALL set vr=1 on the tick where tckc==tckc_top>>1, and vr=0 on the tick where tckc wraps to 0.
REQ-018 SHALL advance tooth on tckc wrap; at TEETH-MISSING-1 it wraps to 0 and asserts rev_stb for exactly one cycle.
REQ-019 SHALL load the live scnt_top from the shadow register at revolution wrap and clear period_pend there.
REQ-020 SHALL, on period_wr, write the shadow and set period_pend; a write coincident with a wrap leaves the old shadow applied, and the new value is applied at the next wrap with period_pend still set.
REQ-021 SHALL hold every register and output when ena=0; ena has no effect during rst.
REQ-022 SHALL evaluate cam events only on tckc wrap, using the tooth index being left: tooth 30 toggles cam_phase; if cam_phase=1 (pre-toggle value), tooth 54 sets cam=0 and tooth 4 sets cam=1.
REQ-023 SHALL let scnt_top=0 produce one tick per cycle; the bench must handle the 8'd255 maximum without overflow.

Reset
REQ-024 SHALL, on rst, set scnt=0, tckc=0, tooth=START_TOOTH, scnt_top=shadow=RST_PERIOD, vr=0, cam=1, cam_phase=0, rev_stb=0, period_pend=0.
REQ-025 SHALL, on rst asserted mid-tooth, discard partial counts and restart from REQ-024 values on the first cycle after release.

Configuration
REQ-026 SHALL compile cam_phase and cam logic only when CRANK_GEN_CAM_EN is defined; otherwise cam SHALL be constant 0 and no cam registers exist.

Structure
REQ-027 SHALL place TEETH/MISSING defaults, tooth tick counts (64, 191), and cam tooth indices (4, 30, 54) in package crank_gen_pkg.
REQ-028 SHALL implement REQ-015 and REQ-019/020 in sub-module tick_prescaler (scnt, live top, shadow, pending flag, tick output).

Verification
REQ-029 SHALL cover: rst, START_TOOTH=0, period_wr 8'd0 then one wrap -> normal tooth 64 cycles, vr high 32 cycles after tooth start, revolution 3840 cycles.
REQ-030 SHALL cover: default period 63 -> tick every 64 cycles, tooth 57 lasts 191+1 ticks with vr rise at tckc 95, rev_stb single cycle at 57->0.
REQ-031 SHALL cover: period_wr 8'd10 mid-revolution -> period_pend=1, spacing unchanged until wrap, then 11-cycle ticks and period_pend=0.
REQ-032 SHALL cover: period_wr coincident with rev_stb -> old shadow applied, new value applied one revolution later.
REQ-033 SHALL cover: ena low for 100 cycles mid-tooth -> vr, cam, tooth, counters frozen; resume continues seamlessly.
REQ-034 SHALL cover: CRANK_GEN_CAM_EN defined, 4 revolutions -> cam low from tooth 54 to tooth 4 only in revolutions where cam_phase=1; undefined -> cam constantly 0.
